// File: rtl/result_display.sv
`default_nettype none
// ============================================================================
//  Module   : result_display
//  Purpose  : Captures a 9-bit calculator result, converts the magnitude to
//             three BCD digits with an iterative shift-add-3 engine, and
//             drives three active-low seven-segment displays plus a blinking
//             overflow LED.
//  Revision : 1.0  initial release
// ============================================================================
module result_display #(
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] result,
  input  logic       load,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic       of_led,
  output logic       busy,
  output logic       done
);

  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t state, state_next;

  logic [7:0]    bin;
  logic [11:0]   bcd;
  logic          ovf_work;
  logic [2:0]    iter;
  logic          ovf_latched;
  logic [BW-1:0] blink_cnt;

  logic [11:0]   bcd_adj;
  logic [19:0]   shifted;
  logic          blink_wrap;

  // Digit to active-low segment pattern (bit0 = a ... bit6 = g).
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Add-3 correction on every BCD nibble that is 5 or more, then one-bit shift.
  always_comb begin
    bcd_adj[3:0]   = (bcd[3:0]   >= 4'd5) ? bcd[3:0]   + 4'd3 : bcd[3:0];
    bcd_adj[7:4]   = (bcd[7:4]   >= 4'd5) ? bcd[7:4]   + 4'd3 : bcd[7:4];
    bcd_adj[11:8]  = (bcd[11:8]  >= 4'd5) ? bcd[11:8]  + 4'd3 : bcd[11:8];
    shifted        = {bcd_adj, bin} << 1;
  end

  assign busy       = (state != IDLE);
  assign blink_wrap = (blink_cnt == BLINK_LAST);

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // FSM next-state logic; load only matters in IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load) state_next = SHIFT;
      SHIFT:   if (iter == 3'd7) state_next = LATCH;
      LATCH:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Conversion datapath and registered display outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin         <= 8'd0;
      bcd         <= 12'd0;
      ovf_work    <= 1'b0;
      iter        <= 3'd0;
      ovf_latched <= 1'b0;
      hex0        <= SEG_BLANK;
      hex1        <= SEG_BLANK;
      hex2        <= SEG_BLANK;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            bin      <= result[7:0];
            ovf_work <= result[8];
            bcd      <= 12'd0;
            iter     <= 3'd0;
          end
        end
        SHIFT: begin
          bcd  <= shifted[19:8];
          bin  <= shifted[7:0];
          iter <= iter + 3'd1;
        end
        LATCH: begin
          ovf_latched <= ovf_work;
          done        <= 1'b1;
          if (ovf_work) begin
            hex0 <= SEG_DASH;
            hex1 <= SEG_DASH;
            hex2 <= SEG_DASH;
          end else begin
            // Leading zeros are blanked; the ones digit always shows.
            hex0 <= seg7(bcd[3:0]);
            hex1 <= (bcd[11:4] == 8'd0) ? SEG_BLANK : seg7(bcd[7:4]);
            hex2 <= (bcd[11:8] == 4'd0) ? SEG_BLANK : seg7(bcd[11:8]);
          end
        end
        default: ;
      endcase
    end
  end

  // Free-running blink divider; a fresh overflow restarts it with the LED on.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt <= '0;
      of_led    <= 1'b0;
    end else if (state == LATCH && ovf_work) begin
      blink_cnt <= '0;
      of_led    <= 1'b1;
    end else begin
      blink_cnt <= blink_wrap ? '0 : blink_cnt + BW'(1);
      if (state == LATCH || !ovf_latched) of_led <= 1'b0;
      else if (blink_wrap)                of_led <= ~of_led;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_result_display.sv
`default_nettype none
// ============================================================================
//  Module   : tb_result_display
//  Purpose  : Self-checking bench for result_display. Expected displays are
//             queued when a load is issued and compared by a monitor on done.
//  Revision : 1.0  initial release
// ============================================================================
module tb_result_display;

  localparam int BLINK_DIV = 4;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] DA = 7'b0111111;

  typedef struct packed {
    logic [6:0] h2;
    logic [6:0] h1;
    logic [6:0] h0;
    logic       led;
  } disp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load = 1'b0;
  logic [8:0] result = 9'd0;
  logic [6:0] hex0, hex1, hex2;
  logic       of_led, busy, done;

  disp_t exp_q[$];
  int    passed = 0;
  int    total  = 0;

  result_display #(.BLINK_DIV(BLINK_DIV)) dut (
    .clk    (clk),
    .reset  (reset),
    .result (result),
    .load   (load),
    .hex0   (hex0),
    .hex1   (hex1),
    .hex2   (hex2),
    .of_led (of_led),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && done === 1'b1) begin
      disp_t e;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("display", {10'd0, hex2, hex1, hex0, of_led}, 32'(e));
      end
    end
  end

  // Issue one load, measure the busy window and confirm done follows it.
  task automatic do_load(input logic [8:0] r, input disp_t e, input string tag);
    int n;
    @(negedge clk);
    result = r;
    load   = 1'b1;
    exp_q.push_back(e);
    n = 0;
    @(negedge clk);
    load = 1'b0;
    while (busy === 1'b1 && n < 30) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 32'(n), 32'd9);
    check({tag, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
  endtask

  initial begin
    int dc;
    int bad;

    // Asynchronous reset mid-cycle, before any clock edge.
    #3 reset = 1'b1;
    #1;
    check("rst_hex0", 32'(hex0), 32'(BL));
    check("rst_hex1", 32'(hex1), 32'(BL));
    check("rst_hex2", 32'(hex2), 32'(BL));
    check("rst_flags", {29'd0, of_led, busy, done}, 32'd0);
    repeat (20) @(negedge clk);
    check("rst_held", {10'd0, hex2, hex1, hex0, busy}, {10'd0, BL, BL, BL, 1'b0});
    reset = 1'b0;

    do_load(9'h0FF, '{S2, S5, S5, 1'b0}, "v255");
    do_load(9'h007, '{BL, BL, S7, 1'b0}, "v7");
    do_load(9'h000, '{BL, BL, S0, 1'b0}, "v0");
    do_load(9'h00A, '{BL, S1, S0, 1'b0}, "v10");

    // Overflow: dashes, LED on at latch and toggling every BLINK_DIV cycles.
    do_load(9'h100, '{DA, DA, DA, 1'b1}, "ovf");
    repeat (3) @(negedge clk);
    check("blink_hold", 32'(of_led), 32'd1);
    @(negedge clk);
    check("blink_off", 32'(of_led), 32'd0);
    repeat (4) @(negedge clk);
    check("blink_on", 32'(of_led), 32'd1);
    check("ovf_dash_kept", {11'd0, hex2, hex1, hex0}, {11'd0, DA, DA, DA});

    do_load(9'h005, '{BL, BL, S5, 1'b0}, "v5");

    // A load arriving mid-conversion is lost.
    @(negedge clk);
    result = 9'h02A;
    load   = 1'b1;
    exp_q.push_back('{BL, S4, S2, 1'b0});
    @(negedge clk);
    load = 1'b0;
    repeat (2) @(negedge clk);
    result = 9'h099;
    load   = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_done("repulse");

    // Reset in the middle of a conversion aborts it.
    @(negedge clk);
    result = 9'h0C8;
    load   = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_blank", {11'd0, hex2, hex1, hex0}, {11'd0, BL, BL, BL});
    @(negedge clk);
    reset = 1'b0;
    dc = 0;
    repeat (15) begin
      @(negedge clk);
      if (done === 1'b1) dc++;
    end
    check("abort_no_done", 32'(dc), 32'd0);
    check("abort_still_blank", {11'd0, hex2, hex1, hex0}, {11'd0, BL, BL, BL});

    // load held high: re-trigger every 10 cycles.
    @(negedge clk);
    result = 9'h064;
    load   = 1'b1;
    repeat (4) exp_q.push_back('{S1, S0, S0, 1'b0});
    dc  = 0;
    bad = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        dc++;
        if (i % 10 != 0) bad++;
      end
    end
    load = 1'b0;
    check("held_done_count", 32'(dc), 32'd4);
    check("held_done_spacing", 32'(bad), 32'd0);

    repeat (12) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
